// File: rtl/round_key_sequencer.sv
// -----------------------------------------------------------------------------
// round_key_sequencer
//   AES-128 key expansion engine with a random-access round-key read port.
//   A key_load pulse captures the cipher key as round key 0; the following
//   NUM_ROUNDS cycles each derive and store one further round key through a
//   single shared RotWord/SubWord/RCON path. Reads are served from storage as
//   soon as the requested round is present, otherwise they stall until it is.
//
// Ports
//   clk        in   1    clock, rising edge
//   n_rst      in   1    asynchronous active-low reset
//   key_load   in   1    pulse: capture key_in and (re)start expansion
//   key_in     in   128  cipher key, byte 0 in [127:120]
//   busy       out  1    expansion in progress
//   key_ready  out  1    all NUM_ROUNDS+1 round keys stored
//   rk_req     in   1    read request, held until rk_valid
//   rk_index   in   4    requested round 0..NUM_ROUNDS
//   rk_reverse in   1    (KEYSEQ_REVERSE_EN only) read in decryption order
//   rk_valid   out  1    one-cycle pulse, rk_data/rk_err valid
//   rk_data    out  128  round key, word 0 in [127:96]; holds between pulses
//   rk_err     out  1    rk_index out of range (rk_data is zero)
//
// Build option
//   KEYSEQ_REVERSE_EN  adds rk_reverse; effective index = NUM_ROUNDS-rk_index.
// -----------------------------------------------------------------------------
module round_key_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_index,
`ifdef KEYSEQ_REVERSE_EN
  input  logic         rk_reverse,
`endif
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_err
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t              state;
  logic [3:0]          rnd;        // round being produced while in EXPAND
  logic [127:0]        prev_key;   // last stored round key, feeds the next round
  logic [127:0]        rk_mem [0:NUM_ROUNDS];
  logic [NUM_ROUNDS:0] rk_stored;
  logic [127:0]        next_key;
  logic [3:0]          eff_idx;
  logic                out_range;

  // Next round key: one RotWord/SubWord/RCON word followed by a 4-word chain.
  always_comb begin
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;
    // NOTE: every variable gets a value on every pass, so no latch is inferred.
    temp     = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon(rnd), 24'h0};
    n0       = prev_key[127:96] ^ temp;
    n1       = prev_key[95:64]  ^ n0;
    n2       = prev_key[63:32]  ^ n1;
    n3       = prev_key[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Range check always uses the raw index; only the storage lookup is remapped.
  assign out_range = (rk_index > LAST_ROUND);
`ifdef KEYSEQ_REVERSE_EN
  assign eff_idx = rk_reverse ? (LAST_ROUND - rk_index) : rk_index;
`else
  assign eff_idx = rk_index;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      prev_key  <= '0;
      busy      <= 1'b0;
      key_ready <= 1'b0;
      rk_valid  <= 1'b0;
      rk_err    <= 1'b0;
      rk_data   <= '0;
      rk_stored <= '0;
      // NOTE: the key store is cleared on reset so no key material survives it.
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_mem[i] <= '0;
    end else begin
      // ---------------- expansion FSM ----------------
      if (key_load) begin
        // Load wins in every state: abort any expansion and start over.
        state     <= EXPAND;
        rk_mem[0] <= key_in;
        prev_key  <= key_in;
        rk_stored <= {{NUM_ROUNDS{1'b0}}, 1'b1};
        rnd       <= 4'd1;
        busy      <= 1'b1;
        key_ready <= 1'b0;
      end else if (state == EXPAND) begin
        rk_mem[rnd]    <= next_key;
        rk_stored[rnd] <= 1'b1;
        prev_key       <= next_key;
        rnd            <= rnd + 4'd1;
        if (rnd == LAST_ROUND) begin
          state     <= READY;
          busy      <= 1'b0;
          key_ready <= 1'b1;
        end
      end

      // ---------------- read port ----------------
      // rk_stored is sampled before this edge's write, so a read that collides
      // with the write of its own round waits one cycle and sees the new key.
      // A read coinciding with key_load is held so it restarts on new storage.
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      if (rk_req) begin
        if (out_range) begin
          rk_valid <= 1'b1;
          rk_err   <= 1'b1;
          rk_data  <= '0;
        end else if (!key_load && rk_stored[eff_idx]) begin
          rk_valid <= 1'b1;
          rk_data  <= rk_mem[eff_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_key_sequencer
//   Directed bench for round_key_sequencer (NUM_ROUNDS = 10) using FIPS-197
//   key-expansion vectors. Inputs change 1 ns after a rising edge and outputs
//   are sampled at the same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_round_key_sequencer;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         n_rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         busy;
  logic         key_ready;
  logic         rk_req;
  logic [3:0]   rk_index;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         rk_err;
`ifdef KEYSEQ_REVERSE_EN
  logic         rk_reverse;
`endif

  int n_pass  = 0;
  int n_total = 0;

  round_key_sequencer #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .busy      (busy),
    .key_ready (key_ready),
    .rk_req    (rk_req),
    .rk_index  (rk_index),
`ifdef KEYSEQ_REVERSE_EN
    .rk_reverse(rk_reverse),
`endif
    .rk_valid  (rk_valid),
    .rk_data   (rk_data),
    .rk_err    (rk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a read and wait (bounded) for rk_valid; returns cycles waited.
  task automatic do_read(input logic [3:0] idx, input int budget, output int lat);
    rk_req   = 1'b1;
    rk_index = idx;
    lat      = 0;
    do begin
      tick();
      lat++;
    end while (rk_valid !== 1'b1 && lat < budget);
    rk_req = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    int lat;
    int cnt;
    n_rst    = 1'b0;
    key_load = 1'b0;
    key_in   = '0;
    rk_req   = 1'b0;
    rk_index = 4'd0;
`ifdef KEYSEQ_REVERSE_EN
    rk_reverse = 1'b0;
`endif

    // ---- reset state ----
    #3;
    check("rst_busy",      busy,      0);
    check("rst_key_ready", key_ready, 0);
    check("rst_rk_valid",  rk_valid,  0);
    check("rst_rk_err",    rk_err,    0);
    check("rst_rk_data",   rk_data,   0);
    #19 n_rst = 1'b1;
    tick();

    // ---- full expansion of the FIPS-197 key ----
    load_key(KEY_A);
    check("a_busy_after_load", busy,      1);
    check("a_ready_after_load", key_ready, 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("a_busy_cycles", cnt,       10);
    check("a_key_ready",   key_ready, 1);
    check("a_busy_low",    busy,      0);

    do_read(4'd0, 5, lat);
    check("a_r0_lat",  lat,     1);
    check("a_r0_data", rk_data, KEY_A);
    check("a_r0_err",  rk_err,  0);
    do_read(4'd1, 5, lat);
    check("a_r1_lat",  lat,     1);
    check("a_r1_data", rk_data, A_R1);
    tick();
    check("a_hold_valid", rk_valid, 0);
    check("a_hold_data",  rk_data,  A_R1);
    do_read(4'd10, 5, lat);
    check("a_r10_lat",  lat,     1);
    check("a_r10_data", rk_data, A_R10);

    // ---- out-of-range indices ----
    do_read(4'd12, 5, lat);
    check("oor12_lat",   lat,      1);
    check("oor12_valid", rk_valid, 1);
    check("oor12_err",   rk_err,   1);
    check("oor12_data",  rk_data,  0);
    do_read(4'd11, 5, lat);
    check("oor11_lat", lat,    1);
    check("oor11_err", rk_err, 1);

    // ---- request held unchanged: one pulse per cycle ----
    rk_req   = 1'b1;
    rk_index = 4'd10;
    tick();
    check("held_valid1", rk_valid, 1);
    tick();
    check("held_valid2", rk_valid, 1);
    check("held_data2",  rk_data,  A_R10);
    check("held_err2",   rk_err,   0);
    rk_req = 1'b0;
    tick();
    check("held_dropped", rk_valid, 0);

    // ---- reload from READY, read round 10 one cycle after load ----
    load_key(KEY_A);
    check("b_ready_dropped", key_ready, 0);
    check("b_busy",          busy,      1);
    do_read(4'd10, 30, lat);
    check("b_r10_lat",   lat,       11);
    check("b_r10_valid", rk_valid,  1);
    check("b_r10_data",  rk_data,   A_R10);
    check("b_r10_ready", key_ready, 1);

    // ---- reload with zero key mid-expansion, read pending across it ----
    load_key(KEY_A);
    repeat (4) tick();
    rk_req   = 1'b1;
    rk_index = 4'd10;
    key_in   = '0;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("c_busy",  busy,      1);
    check("c_ready", key_ready, 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (rk_valid !== 1'b1 && lat < 30);
    rk_req = 1'b0;
    check("c_r10_lat",  lat,     11);
    check("c_r10_data", rk_data, Z_R10);
    tick();
    do_read(4'd1, 5, lat);
    check("c_r1_data", rk_data, Z_R1);

    // ---- asynchronous reset mid-expansion ----
    load_key(KEY_A);
    tick();
    tick();
    #2 n_rst = 1'b0;
    #1;
    check("d_busy",      busy,      0);
    check("d_key_ready", key_ready, 0);
    check("d_rk_valid",  rk_valid,  0);
    check("d_rk_err",    rk_err,    0);
    check("d_rk_data",   rk_data,   0);
    #3 n_rst = 1'b1;
    tick();
    rk_req   = 1'b1;
    rk_index = 4'd3;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rk_valid === 1'b1) cnt++;
    end
    rk_req = 1'b0;
    check("d_no_valid_after_rst", cnt,       0);
    check("d_busy_idle",          busy,      0);
    check("d_ready_idle",         key_ready, 0);

`ifdef KEYSEQ_REVERSE_EN
    // ---- decryption-order reads ----
    load_key(KEY_A);
    repeat (11) tick();
    rk_reverse = 1'b1;
    do_read(4'd0, 5, lat);
    check("rev_idx0_data", rk_data, A_R10);
    do_read(4'd10, 5, lat);
    check("rev_idx10_data", rk_data, KEY_A);
    do_read(4'd12, 5, lat);
    check("rev_oor_err",  rk_err,  1);
    check("rev_oor_data", rk_data, 0);
    rk_reverse = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of round keys generated after the cipher key; legal 1..10, bounded by the RCON table.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 key_load  input  1  single-cycle pulse; capture key_in and start expansion.
REQ-005 key_in  input  128  cipher key; byte 0 is bits [127:120].
REQ-006 busy  output  1  expansion in progress.
REQ-007 key_ready  output  1  all NUM_ROUNDS+1 round keys valid.
REQ-008 rk_req  input  1  round-key read request; held high until rk_valid.
REQ-009 rk_index  input  4  requested round number 0..NUM_ROUNDS; held stable with rk_req.
REQ-010 rk_valid  output  1  one-cycle pulse; rk_data/rk_err valid this cycle.
REQ-011 rk_data  output  128  requested round key, word 0 in bits [127:96].
REQ-012 rk_err  output  1  asserted with rk_valid when rk_index > NUM_ROUNDS.

Function
REQ-013 FSM states IDLE, EXPAND, READY; IDLE->EXPAND on key_load; EXPAND->READY after round NUM_ROUNDS is stored; READY->EXPAND on key_load.
REQ-014 On the key_load edge, key_in is stored as round key 0, round counter set to 1, all other stored round keys marked invalid.
REQ-015 EXPAND: one round per cycle via one shared RotWord/SubWord/RCON path plus a 4-word XOR chain; round k written at the k-th edge after the load edge.
REQ-016 RCON for round k: 01,02,04,08,10,20,40,80,1b,36 for k=1..10; SubWord uses the FIPS-197 S-box.
REQ-017 busy is high from the edge after load through the edge writing round NUM_ROUNDS; key_ready rises the same edge busy falls.
REQ-018 key_load during EXPAND or READY aborts and restarts from REQ-014 with the new key; key_ready drops on that edge.
REQ-019 Read: rk_valid pulses the edge after rk_req is sampled with the requested round already stored; otherwise rk_valid is withheld until it is stored.
REQ-020 Out-of-range rk_index: rk_valid next cycle, rk_err=1, rk_data=0, no stall.
REQ-021 Read and write of the same round on the same edge: the read waits one cycle and returns the new value.
REQ-022 After rk_valid, rk_req must drop or change rk_index; if held unchanged, one further rk_valid per cycle is issued.
REQ-023 key_load while a read is pending: the read restarts against the new key's storage; no stale data is returned.
REQ-024 rk_data holds its last value while rk_valid is low.

Reset
REQ-025 n_rst low asynchronously forces IDLE, busy=0, key_ready=0, rk_valid=0, rk_err=0, rk_data=0, all round keys invalid and zero.
REQ-026 Reset asserted mid-expansion discards all progress; a new key_load is required after release.

Configuration
REQ-027 Macro KEYSEQ_REVERSE_EN defined: adds input rk_reverse (1 bit); when high, the effective index is NUM_ROUNDS-rk_index (decryption order); the range check applies to the raw rk_index.
REQ-028 Macro KEYSEQ_REVERSE_EN undefined: no rk_reverse port; the effective index is rk_index.

Verification
REQ-029 Load 2b7e151628aed2a6abf7158809cf4f3c -> busy for 10 cycles, then key_ready; round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 Request round 10 one cycle after load -> rk_valid is withheld until round 10 is stored, then fires the next cycle with the correct value.
REQ-031 rk_index=12 in READY -> rk_valid next cycle, rk_err=1, rk_data=0.
REQ-032 Reload with an all-zero key at expansion cycle 5 -> restart; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 Assert n_rst mid-expansion -> all outputs zero immediately; a later read with no new load never returns rk_valid.
REQ-034 KEYSEQ_REVERSE_EN build, rk_reverse=1, rk_index=0 -> returns round 10 value d014f9a8c9ee2589e13f0cc8b6630ca6.
